// File: rtl/sfx_pkg.sv
// -----------------------------------------------------------------------------
// sfx_pkg
// Shared definitions for the one-shot sound-effect scheduler:
//   - scheduler state encoding (IDLE / WAIT_EDGE / HOLD)
//   - default sfx code width
//   - SFX_NONE: the "no effect" code, never queued or launched
//   - width of the note-tick hold counter (covers HOLD_NOTES up to 15)
// -----------------------------------------------------------------------------
package sfx_pkg;

  localparam int SFX_W_DEF = 16;
  localparam int SFX_NONE  = 0;
  localparam int HOLD_W    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    HOLD      = 2'd2
  } state_t;

endpackage

// File: rtl/sfx_fifo.sv
// -----------------------------------------------------------------------------
// sfx_fifo
// Small synchronous FIFO holding queued sfx codes.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (pointers/count only)
//   i_push       : write i_data (ignored while full)
//   i_pop        : advance read pointer (ignored while empty)
//   i_flush      : discard all entries; overrides push and pop
//   i_data       : code to write
//   o_head       : code at the read pointer (valid while o_count != 0)
//   o_count      : occupancy, 0..DEPTH
//   o_full       : occupancy equals DEPTH
// Parameters: DEPTH (power of two, 2..16), SFX_W.
// -----------------------------------------------------------------------------
module sfx_fifo #(
  parameter int DEPTH = 4,
  parameter int SFX_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [SFX_W-1:0]         i_data,
  output logic [SFX_W-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [SFX_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & (r_count != '0);
  assign o_head    = r_mem[r_rd];
  assign o_count   = r_count;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/sfx_scheduler.sv
// -----------------------------------------------------------------------------
// sfx_scheduler
// Queues sound-effect requests and launches them one at a time on the
// one-shot path, aligned to note-clock rising edges with HOLD_NOTES note ticks
// of quiet after every launch.
// Ports:
//   clk          : slow audio clock (chip_clk domain)
//   reset        : synchronous, active-high
//   note_clk     : note clock level from the beat counter (same domain)
//   req_valid    : request strobe from game logic
//   req_sfx      : requested code; zero is dropped
//   req_urgent   : (SFX_SCHEDULER_PREEMPT_EN only) flush queue and launch
//                  this code on the next note edge
//   req_ready    : queue can accept a request this cycle
//   send_oneshot : one-cycle launch pulse
//   sfx          : code of the current/last launch, held between launches
//   busy         : scheduler not in IDLE
//   fifo_count   : queue occupancy
// Build option: define SFX_SCHEDULER_PREEMPT_EN to add urgent preemption.
// -----------------------------------------------------------------------------
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SFX_W      = SFX_W_DEF,
  parameter int HOLD_NOTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   note_clk,
  input  logic                   req_valid,
`ifdef SFX_SCHEDULER_PREEMPT_EN
  input  logic                   req_urgent,
`endif
  input  logic [SFX_W-1:0]       req_sfx,
  output logic                   req_ready,
  output logic                   send_oneshot,
  output logic [SFX_W-1:0]       sfx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_note_q;
  logic                w_note_rise;
  logic                r_send;
  logic [SFX_W-1:0]    r_sfx;
  logic [HOLD_W-1:0]   r_hold;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_launch;
  logic [SFX_W-1:0]    w_launch_code;
  logic [SFX_W-1:0]    w_head;
  logic                w_full;
  logic                w_code_ok;
`ifdef SFX_SCHEDULER_PREEMPT_EN
  logic                w_urgent;
  logic                r_pre_vld;
  logic [SFX_W-1:0]    r_pre_code;
`endif

  assign w_note_rise  = note_clk & ~r_note_q;
  assign w_code_ok    = (req_sfx != SFX_W'(SFX_NONE));
  assign req_ready    = ~w_full;
  assign send_oneshot = r_send;
  assign sfx          = r_sfx;
  assign busy         = (r_state != IDLE);
`ifdef SFX_SCHEDULER_PREEMPT_EN
  assign w_urgent     = req_valid & req_urgent & w_code_ok;
`endif

  sfx_fifo #(
    .DEPTH (DEPTH),
    .SFX_W (SFX_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (req_sfx),
    .o_head  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_launch      = 1'b0;
    w_pop         = 1'b0;
    w_flush       = 1'b0;
    w_push        = req_valid & req_ready & w_code_ok;
    w_launch_code = w_head;
    case (r_state)
      // Edges seen while still in IDLE are deliberately ignored.
      IDLE: begin
        if (fifo_count != '0) w_state_nxt = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (w_note_rise) begin
          w_launch    = 1'b1;
          w_state_nxt = HOLD;
`ifdef SFX_SCHEDULER_PREEMPT_EN
          if (r_pre_vld) w_launch_code = r_pre_code;
          else           w_pop         = 1'b1;
`else
          w_pop = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (w_note_rise && r_hold <= HOLD_W'(1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef SFX_SCHEDULER_PREEMPT_EN
    // Urgent request wins over everything else happening this cycle.
    if (w_urgent) begin
      w_state_nxt = WAIT_EDGE;
      w_launch    = 1'b0;
      w_pop       = 1'b0;
      w_push      = 1'b0;
      w_flush     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_note_q  <= 1'b0;
      r_send    <= 1'b0;
      r_sfx     <= SFX_W'(SFX_NONE);
      r_hold    <= '0;
`ifdef SFX_SCHEDULER_PREEMPT_EN
      r_pre_vld <= 1'b0;
`endif
    end else begin
      r_note_q <= note_clk;
      r_send   <= w_launch;
      if (w_launch) begin
        r_sfx  <= w_launch_code;
        r_hold <= HOLD_W'(HOLD_NOTES);
      end else if (r_state == HOLD && w_note_rise && r_hold != '0) begin
        r_hold <= r_hold - 1'b1;
      end
`ifdef SFX_SCHEDULER_PREEMPT_EN
      if (w_urgent) begin
        r_hold    <= '0;
        r_pre_vld <= 1'b1;
      end else if (w_launch) begin
        r_pre_vld <= 1'b0;
      end
`endif
    end
  end

`ifdef SFX_SCHEDULER_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (w_urgent) r_pre_code <= req_sfx;
  end
`endif

endmodule

// File: tb/tb_sfx_scheduler.sv
module tb_sfx_scheduler;

  localparam int DEPTH      = 4;
  localparam int SFX_W      = 16;
  localparam int HOLD_NOTES = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              note_clk = 1'b0;
  logic              req_valid = 1'b0;
  logic [SFX_W-1:0]  req_sfx = '0;
  logic              req_ready;
  logic              send_oneshot;
  logic [SFX_W-1:0]  sfx;
  logic              busy;
  logic [2:0]        fifo_count;
`ifdef SFX_SCHEDULER_PREEMPT_EN
  logic              req_urgent = 1'b0;
`endif

  sfx_scheduler #(
    .DEPTH      (DEPTH),
    .SFX_W      (SFX_W),
    .HOLD_NOTES (HOLD_NOTES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .note_clk     (note_clk),
    .req_valid    (req_valid),
`ifdef SFX_SCHEDULER_PREEMPT_EN
    .req_urgent   (req_urgent),
`endif
    .req_sfx      (req_sfx),
    .req_ready    (req_ready),
    .send_oneshot (send_oneshot),
    .sfx          (sfx),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        send;
    bit [15:0] sfx;
    int        count;
    bit        busy;
  } exp_t;

  exp_t      exp_q[$];   // per-cycle status expectations
  bit [15:0] launch_q[$]; // expected launch codes, in order

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending requests, a flag saying a queued request has
  // been noticed and the next note edge will fire it, and the number of
  // note edges still to sit out after a launch.
  bit [15:0] mq[$];
  bit        armed = 0;
  int        hold_left = 0;
  bit        note_prev = 0;
  bit [15:0] last_sfx = 0;
  bit        note_lvl = 0;
  int        note_ctr = 0;

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus; the model predicts the state after the
  // following rising edge.
  task automatic step(input bit rst_i, input bit v, input bit [15:0] code, input bit note);
    exp_t e;
    bit   rise, noticed, push_ok;
    @(negedge clk);
    reset     = rst_i;
    req_valid = v;
    req_sfx   = code;
    note_clk  = note;
    if (rst_i) begin
      mq.delete();
      armed = 0; hold_left = 0; note_prev = 0; last_sfx = 0;
      e = '{send: 1'b0, sfx: 16'h0, count: 0, busy: 1'b0};
    end else begin
      rise      = note && !note_prev;
      note_prev = note;
      push_ok   = v && (code != 0) && (mq.size() < DEPTH);
      noticed   = !armed && (hold_left == 0) && (mq.size() > 0);
      e.send    = 1'b0;
      if (armed && rise) begin
        last_sfx = mq.pop_front();
        launch_q.push_back(last_sfx);
        e.send    = 1'b1;
        armed     = 0;
        hold_left = HOLD_NOTES;
      end else if (hold_left > 0 && rise) begin
        hold_left--;
      end
      if (noticed) armed = 1;
      if (push_ok) mq.push_back(code);
      e.sfx   = last_sfx;
      e.count = mq.size();
      e.busy  = armed || (hold_left > 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic quiet(input int n, input bit note);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, note);
  endtask

  task automatic toggle(input int n, input int half);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, ((i / half) % 2) == 1);
  endtask

  task automatic rand_run(input int n, input int rst_permil);
    bit [15:0] code;
    bit        r;
    for (int i = 0; i < n; i++) begin
      if (note_ctr <= 0) begin
        note_lvl = ~note_lvl;
        note_ctr = $urandom_range(1, 4);
      end
      note_ctr--;
      code = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      r    = ($urandom_range(0, 999) < rst_permil);
      step(r, $urandom_range(0, 1) == 1, code, note_lvl);
    end
  endtask

  // Monitor: one status check per cycle, plus launch scoreboard on pulses.
  initial begin
    exp_t e;
    bit [15:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("send_oneshot", send_oneshot, e.send);
        chk("sfx", sfx, e.sfx);
        chk("fifo_count", fifo_count, e.count);
        chk("busy", busy, e.busy);
        chk("req_ready", req_ready, e.count < DEPTH);
        if (send_oneshot === 1'b1) begin
          if (launch_q.size() == 0) begin
            chk("unexpected_launch", 1, 0);
          end else begin
            want = launch_q.pop_front();
            chk("launch_code", sfx, want);
          end
        end
      end
    end
  end

  initial begin
    // Reset
    repeat (3) step(1, 0, 16'h0, 0);

    // Single launch: push while idle, note rises 5 cycles after the push
    step(0, 1, 16'h0001, 0);
    quiet(4, 0);
    quiet(3, 1);
    quiet(3, 0);
    toggle(30, 2);

    // Spacing: three back-to-back pushes
    step(0, 1, 16'h0001, 0);
    step(0, 1, 16'h0002, 0);
    step(0, 1, 16'h0003, 0);
    toggle(60, 3);

    // Full and zero handling: five pushes into a depth-4 queue, then a zero
    quiet(2, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 16'h0010 + 16'(i), 0);
    step(0, 1, 16'h0000, 0);
    quiet(3, 0);
    toggle(80, 2);

    // Simultaneous push and launch pop with two entries queued
    step(0, 1, 16'h0021, 0);
    step(0, 1, 16'h0022, 0);
    quiet(3, 0);
    step(0, 1, 16'h0023, 1);
    quiet(2, 1);
    toggle(60, 2);

    // Reset mid-HOLD with three entries still queued
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0031 + 16'(i), 0);
    quiet(3, 0);
    step(0, 0, 16'h0, 1);
    quiet(2, 1);
    step(1, 0, 16'h0, 0);
    quiet(3, 0);

    // Randomized traffic, including occasional resets
    rand_run(3000, 3);
    step(0, 0, 16'h0, 0);

    @(posedge clk);
    #2;
    chk("pending_launches", launch_q.size(), 0);
    chk("pending_status", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
